raw_stream_arb: RTL
===================

Name: raw_stream_arb

Overview:
- Frame-granular round-robin arbiter/sequencer for two dtype-framed 16-bit raw imager streams sharing one downstream raw-to-32 packer.
- Grants one source per whole frame and muxes its stream onto the packer input.
- Latches that source's pack and image_type configuration for the frame.
- Inserts an idle gap after each frame so the packer's deferred lsb flush and row-end output complete before the next source starts.

Parameters:
- FLUSH_CYCLES, 4: number of dvo-low cycles forced after a FRAME_END before the next grant (must be ≥2).
- TIMEOUT, 1024: cycles to wait for FRAME_START after a grant before releasing (counter width clog2(TIMEOUT+1)).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req  in  2  per-source frame-ready request; level, held until granted frame ends
- gnt  out  2  one-hot grant; source streams only while its bit is set
- datai0  in  16  source 0 pixel/header data
- dvi0  in  1  source 0 data valid
- dtypei0  in  `DTYPE_WIDTH  source 0 dtype
- pack0  in  1  source 0 pack-10-bit request
- image_type0  in  16  source 0 image type
- datai1, dvi1, dtypei1, pack1, image_type1: same as source 0, for source 1
- datao  out  16  muxed data to packer
- dvo  out  1  muxed data valid
- dtypeo  out  `DTYPE_WIDTH  muxed dtype
- packo  out  1  pack setting latched at grant
- image_typeo  out  16  image type latched at grant
- active  out  1  high from grant through end of FLUSH
- timeout_err  out  1  one-cycle pulse on grant timeout

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer favours source 0.
  - Counters 0.
- States:
  - IDLE: if any req bit is set, grant the favoured source when it requests, else the other. Set gnt one-hot, latch packo/image_typeo from the winner's pack/image_type, clear the timeout counter, set active, go to WAIT_SOF. Same cycle as detection; gnt is valid on the next edge.
  - WAIT_SOF: forward only a beat with dvi_g=1 and dtypei_g==`DTYPE_FRAME_START, then go to STREAM. Other dtypes from the granted source are dropped (dvo=0). Each cycle increments the counter. Reaching TIMEOUT: pulse timeout_err, drop gnt, go to FLUSH, and still flip the pointer.
  - STREAM: registered mux of the granted source's datai/dvi/dtypei to datao/dvo/dtypeo (1-cycle latency, no bubbles inserted). When a beat with dtypei_g==`DTYPE_FRAME_END is forwarded, clear gnt in the same edge and go to FLUSH.
  - FLUSH: dvo=0 for FLUSH_CYCLES cycles; datao/dtypeo hold their last value. Then clear active, flip the pointer to favour the other source, and go to IDLE.
- The non-granted source's dvi is always ignored; no data from it ever reaches dvo.
- packo/image_typeo are stable from grant until the next grant; mid-frame changes to pack/image_type inputs are ignored.
- req deasserting while granted does not end the frame; only FRAME_END or timeout ends it.
- A second FRAME_START in STREAM is forwarded unchanged; no protocol checking beyond FRAME_END detection.
- Both req set in IDLE: the pointer decides. A single requester is re-granted after its own FLUSH with no penalty.
- No req: stays IDLE, dvo=0.
- Reset mid-frame: immediate return to the reset state; the packer is reset by the same reset.

Test Plan:
- Source 0 only, pack0=1, frame of FRAME_START, 8×PIXEL, ROW_END, FRAME_END:
  - gnt=01 one cycle after req.
  - 11 beats appear on dvo with 1-cycle latency.
  - packo=1 throughout.
  - gnt=00 after FRAME_END; then 4 dvo-low cycles; then IDLE.
- req=11 held, each source sends 3 frames: grants alternate 01,10,01,10,01,10; output beats never interleave between sources.
- Source 1 granted but never sends FRAME_START: timeout_err pulses exactly TIMEOUT cycles after grant, then FLUSH, then source 0 (req set) is granted.
- Source 0 sends PIXEL beats before FRAME_START after grant: those beats are dropped (dvo=0); the stream starts at FRAME_START.
- pack0 toggles 1→0 and image_type0 changes 0x0003→0x0007 mid-frame: packo=1 and image_typeo=0x0003 hold until the next grant.
- Reset asserted in STREAM mid-row: gnt, dvo, and active go to 0 asynchronously; after release a fresh req0 is granted normally.

Source files
------------

// File: rtl/raw_stream_arb.sv
// Frame-granular round-robin arbiter for two dtype-framed 16-bit raw imager streams
// feeding one shared raw-to-32 packer; inserts a flush gap after every frame.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL (`DTYPE_WIDTH'(0))
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START (`DTYPE_WIDTH'(1))
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END (`DTYPE_WIDTH'(2))
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END (`DTYPE_WIDTH'(3))
`endif

module raw_stream_arb #(
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req,
  output logic [1:0]              gnt,
  input  logic [15:0]             datai0,
  input  logic                    dvi0,
  input  logic [`DTYPE_WIDTH-1:0] dtypei0,
  input  logic                    pack0,
  input  logic [15:0]             image_type0,
  input  logic [15:0]             datai1,
  input  logic                    dvi1,
  input  logic [`DTYPE_WIDTH-1:0] dtypei1,
  input  logic                    pack1,
  input  logic [15:0]             image_type1,
  output logic [15:0]             datao,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic                    packo,
  output logic [15:0]             image_typeo,
  output logic                    active,
  output logic                    timeout_err
);

  localparam int unsigned DW = `DTYPE_WIDTH;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [DW-1:0] DT_FS = `DTYPE_FRAME_START;
  localparam logic [DW-1:0] DT_FE = `DTYPE_FRAME_END;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t state, state_nxt;

  logic          ptr, ptr_nxt;
  logic          sel, sel_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;

  logic [1:0]    gnt_nxt;
  logic [15:0]   datao_nxt;
  logic          dvo_nxt;
  logic [DW-1:0] dtypeo_nxt;
  logic          packo_nxt;
  logic [15:0]   image_typeo_nxt;
  logic          active_nxt;
  logic          timeout_err_nxt;

  logic [15:0]   data_g;
  logic          dv_g;
  logic [DW-1:0] dt_g;
  logic          win;
  logic          sof_hit;
  logic          eof_hit;
  logic          tmo_hit;
  logic          flush_done;

  // Only the granted source is ever looked at; the other one's dvi never matters.
  assign data_g = sel ? datai1  : datai0;
  assign dv_g   = sel ? dvi1    : dvi0;
  assign dt_g   = sel ? dtypei1 : dtypei0;

  assign win        = req[ptr] ? ptr : ~ptr;
  assign sof_hit    = dv_g && (dt_g == DT_FS);
  assign eof_hit    = dv_g && (dt_g == DT_FE);
  assign tmo_hit    = (tcnt == TW'(TIMEOUT - 1));
  assign flush_done = (fcnt == FW'(FLUSH_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (|req) state_nxt = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        if (sof_hit)      state_nxt = S_STREAM;
        else if (tmo_hit) state_nxt = S_FLUSH;
      end
      S_STREAM: begin
        if (eof_hit) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Computes the next value of every registered output; anything not assigned holds.
  always_comb begin : outputs
    gnt_nxt         = gnt;
    datao_nxt       = datao;
    dvo_nxt         = 1'b0;
    dtypeo_nxt      = dtypeo;
    packo_nxt       = packo;
    image_typeo_nxt = image_typeo;
    active_nxt      = active;
    timeout_err_nxt = 1'b0;
    ptr_nxt         = ptr;
    sel_nxt         = sel;
    tcnt_nxt        = tcnt;
    fcnt_nxt        = fcnt;
    unique case (state)
      S_IDLE: begin
        if (|req) begin
          gnt_nxt         = win ? 2'b10 : 2'b01;
          sel_nxt         = win;
          packo_nxt       = win ? pack1 : pack0;
          image_typeo_nxt = win ? image_type1 : image_type0;
          tcnt_nxt        = '0;
          active_nxt      = 1'b1;
        end
      end
      S_WAIT_SOF: begin
        if (sof_hit) begin
          datao_nxt  = data_g;
          dvo_nxt    = 1'b1;
          dtypeo_nxt = dt_g;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
          if (tmo_hit) begin
            timeout_err_nxt = 1'b1;
            gnt_nxt         = '0;
            fcnt_nxt        = '0;
          end
        end
      end
      S_STREAM: begin
        datao_nxt  = data_g;
        dvo_nxt    = dv_g;
        dtypeo_nxt = dt_g;
        if (eof_hit) begin
          gnt_nxt  = '0;
          fcnt_nxt = '0;
        end
      end
      S_FLUSH: begin
        fcnt_nxt = fcnt + FW'(1);
        if (flush_done) begin
          active_nxt = 1'b0;
          ptr_nxt    = ~sel;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin : datapath_reg
    if (reset) begin
      gnt         <= '0;
      datao       <= '0;
      dvo         <= 1'b0;
      dtypeo      <= '0;
      packo       <= 1'b0;
      image_typeo <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
      ptr         <= 1'b0;
      sel         <= 1'b0;
      tcnt        <= '0;
      fcnt        <= '0;
    end else begin
      gnt         <= gnt_nxt;
      datao       <= datao_nxt;
      dvo         <= dvo_nxt;
      dtypeo      <= dtypeo_nxt;
      packo       <= packo_nxt;
      image_typeo <= image_typeo_nxt;
      active      <= active_nxt;
      timeout_err <= timeout_err_nxt;
      ptr         <= ptr_nxt;
      sel         <= sel_nxt;
      tcnt        <= tcnt_nxt;
      fcnt        <= fcnt_nxt;
    end
  end

endmodule
